// File: rtl/dem_ctrl.sv
// dem_ctrl: run/pause/clear controller for the 0-9 demo counter.
// A prescaler issues one-cycle step enables, and an up/down digit counter
// advances on each step. A three-state machine (IDLE/RUN/PAUSE) is driven
// by two edge-detected push-buttons.
// Optional feature macro: DEM_CTRL_DEBOUNCE_EN. When it is defined, each
// synchronized button is debounced over DEB_CYCLES cycles before edge detection.
module dem_ctrl #(
  parameter int TICK_DIV   = 50000000,
  parameter int DEB_CYCLES = 500000
) (
  input  logic       clki,
  input  logic       rst,
  input  logic       btn_run,
  input  logic       btn_clr,
  input  logic       dir,
  output logic [3:0] digit,
  output logic       tick,
  output logic       wrap,
  output logic       running
);

  // Prescaler width and terminal count (TICK_DIV >= 2, so PW >= 1)
  localparam int             PW       = $clog2(TICK_DIV);
  localparam logic [PW-1:0]  PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0]  PRE_ONE  = PW'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  // Next digit, packed as {wrap, value}. The counter stays inside 0..9 even
  // if an out-of-range value ever appeared: it is folded back onto a wrap.
  function automatic logic [4:0] step_digit(input logic [3:0] cur, input logic down);
    logic [4:0] res;
    res = 5'd0;
    if (down) begin
      if (cur == 4'd0 || cur > 4'd9) begin
        res = {1'b1, 4'd9};
      end else begin
        res = {1'b0, cur - 4'd1};
      end
    end else begin
      if (cur >= 4'd9) begin
        res = {1'b1, 4'd0};
      end else begin
        res = {1'b0, cur + 4'd1};
      end
    end
    return res;
  endfunction

  // ---------------------------------------------------------------------
  // Button input path
  // ---------------------------------------------------------------------
  logic [1:0] r_run_sync;
  logic [1:0] r_clr_sync;
  logic       r_run_prev;
  logic       r_clr_prev;
  logic       w_run_lvl;
  logic       w_clr_lvl;
  logic       w_run_press;
  logic       w_clr_press;

  // Two-flop synchronizers bring the asynchronous buttons into clki
  always_ff @(posedge clki or posedge rst) begin
    if (rst) begin
      r_run_sync <= 2'b00;
      r_clr_sync <= 2'b00;
    end else begin
      r_run_sync <= {r_run_sync[0], btn_run};
      r_clr_sync <= {r_clr_sync[0], btn_clr};
    end
  end

`ifdef DEM_CTRL_DEBOUNCE_EN
  localparam int            DW       = $clog2(DEB_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [DW-1:0] DEB_ONE  = DW'(1);

  logic [DW-1:0] r_run_cnt;
  logic [DW-1:0] r_clr_cnt;
  logic          r_run_deb;
  logic          r_clr_deb;

  // Run debounce: adopt the synchronized level after DEB_CYCLES differing cycles
  always_ff @(posedge clki or posedge rst) begin
    if (rst) begin
      r_run_cnt <= '0;
      r_run_deb <= 1'b0;
    end else if (r_run_sync[1] != r_run_deb) begin
      if (r_run_cnt == DEB_LAST) begin
        r_run_deb <= r_run_sync[1];
        r_run_cnt <= '0;
      end else begin
        r_run_cnt <= r_run_cnt + DEB_ONE;
      end
    end else begin
      r_run_cnt <= '0;
    end
  end

  // Clear debounce: same filter as the run button
  always_ff @(posedge clki or posedge rst) begin
    if (rst) begin
      r_clr_cnt <= '0;
      r_clr_deb <= 1'b0;
    end else if (r_clr_sync[1] != r_clr_deb) begin
      if (r_clr_cnt == DEB_LAST) begin
        r_clr_deb <= r_clr_sync[1];
        r_clr_cnt <= '0;
      end else begin
        r_clr_cnt <= r_clr_cnt + DEB_ONE;
      end
    end else begin
      r_clr_cnt <= '0;
    end
  end

  assign w_run_lvl = r_run_deb;
  assign w_clr_lvl = r_clr_deb;
`else
  assign w_run_lvl = r_run_sync[1];
  assign w_clr_lvl = r_clr_sync[1];
`endif

  // Previous-level registers for rising-edge detection
  always_ff @(posedge clki or posedge rst) begin
    if (rst) begin
      r_run_prev <= 1'b0;
      r_clr_prev <= 1'b0;
    end else begin
      r_run_prev <= w_run_lvl;
      r_clr_prev <= w_clr_lvl;
    end
  end

  assign w_run_press = w_run_lvl & ~r_run_prev;
  assign w_clr_press = w_clr_lvl & ~r_clr_prev;

  // ---------------------------------------------------------------------
  // Controller: state, prescaler, digit and registered pulse outputs
  // ---------------------------------------------------------------------
  state_t        r_state;
  logic [PW-1:0] r_presc;
  logic [3:0]    r_digit;
  logic          r_tick;
  logic          r_wrap;
  logic          r_running;
  logic [4:0]    w_step;

  assign w_step = step_digit(r_digit, dir);

  // Single FSM: button presses sequence the state; a step fires only on a
  // press-free terminal-count edge in RUN. Clear always wins over run.
  always_ff @(posedge clki or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_presc   <= '0;
      r_digit   <= 4'd0;
      r_tick    <= 1'b0;
      r_wrap    <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      r_wrap <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_presc <= '0;
          r_digit <= 4'd0;
          if (w_clr_press) begin
            r_state   <= ST_IDLE;
            r_running <= 1'b0;
          end else if (w_run_press) begin
            r_state   <= ST_RUN;
            r_running <= 1'b1;
          end else begin
            r_running <= 1'b0;
          end
        end
        ST_RUN: begin
          if (w_clr_press) begin
            r_state   <= ST_IDLE;
            r_presc   <= '0;
            r_digit   <= 4'd0;
            r_running <= 1'b0;
          end else if (w_run_press) begin
            // Prescaler holds so that resume keeps the phase
            r_state   <= ST_PAUSE;
            r_running <= 1'b0;
          end else if (r_presc == PRE_LAST) begin
            r_presc <= '0;
            r_digit <= w_step[3:0];
            r_wrap  <= w_step[4];
            r_tick  <= 1'b1;
          end else begin
            r_presc <= r_presc + PRE_ONE;
          end
        end
        ST_PAUSE: begin
          if (w_clr_press) begin
            r_state   <= ST_IDLE;
            r_presc   <= '0;
            r_digit   <= 4'd0;
            r_running <= 1'b0;
          end else if (w_run_press) begin
            r_state   <= ST_RUN;
            r_running <= 1'b1;
          end else begin
            r_running <= 1'b0;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_presc   <= '0;
          r_digit   <= 4'd0;
          r_running <= 1'b0;
        end
      endcase
    end
  end

  assign digit   = r_digit;
  assign tick    = r_tick;
  assign wrap    = r_wrap;
  assign running = r_running;

endmodule

// File: tb/tb_dem_ctrl.sv
// Directed testbench for dem_ctrl with TICK_DIV = 4, DEB_CYCLES = 3.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_dem_ctrl;

  logic       clki;
  logic       rst;
  logic       btn_run;
  logic       btn_clr;
  logic       dir;
  logic [3:0] digit;
  logic       tick;
  logic       wrap;
  logic       running;

  int n_checks;
  int n_fail;

  dem_ctrl #(
    .TICK_DIV  (4),
    .DEB_CYCLES(3)
  ) u_dut (
    .clki   (clki),
    .rst    (rst),
    .btn_run(btn_run),
    .btn_clr(btn_clr),
    .dir    (dir),
    .digit  (digit),
    .tick   (tick),
    .wrap   (wrap),
    .running(running)
  );

  initial clki = 1'b0;
  always #5 clki = ~clki;

  task automatic clk1();
    @(posedge clki);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_digit"}, digit, 4'd0);
    chk({tag, "_tick"}, 4'(tick), 4'd0);
    chk({tag, "_wrap"}, 4'(wrap), 4'd0);
    chk({tag, "_running"}, 4'(running), 4'd0);
  endtask

  task automatic do_reset();
    btn_run = 1'b0;
    btn_clr = 1'b0;
    rst     = 1'b1;
    #1;
    chk_all_zero("reset");
    clk1();
    clk1();
    rst = 1'b0;
  endtask

  // Pin high now; press seen after 2 edges; running changes at the 3rd edge
  task automatic press_run(input logic exp_after);
    logic exp_before;
    exp_before = ~exp_after;
    btn_run = 1'b1;
    clk1();
    clk1();
    chk("press_before", 4'(running), 4'(exp_before));
    clk1();
    chk("press_after", 4'(running), 4'(exp_after));
    btn_run = 1'b0;
  endtask

  // Three quiet cycles followed by a step showing the expected digit/wrap
  task automatic expect_step(input string tag, input logic [3:0] exp_d, input logic exp_w);
    for (int k = 0; k < 3; k++) begin
      clk1();
      chk({tag, "_quiet"}, 4'(tick), 4'd0);
    end
    clk1();
    chk({tag, "_tick"}, 4'(tick), 4'd1);
    chk({tag, "_digit"}, digit, exp_d);
    chk({tag, "_wrap"}, 4'(wrap), 4'(exp_w));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    btn_run  = 1'b0;
    btn_clr  = 1'b0;
    dir      = 1'b0;
    clk1();
    do_reset();

`ifndef DEM_CTRL_DEBOUNCE_EN
    // 1: count up through a full wrap
    dir = 1'b0;
    press_run(1'b1);
    for (int i = 1; i <= 10; i++) begin
      logic [3:0] exp_d;
      logic       exp_w;
      exp_d = 4'(i % 10);
      exp_w = (i == 10);
      expect_step("t1", exp_d, exp_w);
    end

    // 2: count down, first step wraps 0 -> 9
    do_reset();
    dir = 1'b1;
    press_run(1'b1);
    expect_step("t2a", 4'd9, 1'b1);
    expect_step("t2b", 4'd8, 1'b0);

    // 3: pause two cycles after a tick, hold, resume keeps phase
    press_run(1'b0);
    chk("t3_pause_tick", 4'(tick), 4'd0);
    chk("t3_pause_digit", digit, 4'd8);
    for (int i = 0; i < 20; i++) begin
      clk1();
      chk("t3_hold_digit", digit, 4'd8);
      chk("t3_hold_tick", 4'(tick), 4'd0);
      chk("t3_hold_run", 4'(running), 4'd0);
    end
    press_run(1'b1);
    clk1();
    chk("t3_resume_quiet", 4'(tick), 4'd0);
    clk1();
    chk("t3_resume_tick", 4'(tick), 4'd1);
    chk("t3_resume_digit", digit, 4'd7);

    // 3b: run press on the terminal-count edge suppresses the step
    clk1();
    press_run(1'b0);
    chk("t3b_no_tick", 4'(tick), 4'd0);
    chk("t3b_digit", digit, 4'd7);
    repeat (5) clk1();
    press_run(1'b1);
    chk("t3b_resume_edge_tick", 4'(tick), 4'd0);
    clk1();
    chk("t3b_step_tick", 4'(tick), 4'd1);
    chk("t3b_step_digit", digit, 4'd6);

    // 4: run and clr together at digit 5 -> IDLE
    do_reset();
    dir = 1'b0;
    press_run(1'b1);
    repeat (20) clk1();
    chk("t4_tick5", 4'(tick), 4'd1);
    chk("t4_digit5", digit, 4'd5);
    btn_run = 1'b1;
    btn_clr = 1'b1;
    clk1();
    clk1();
    chk("t4_before_run", 4'(running), 4'd1);
    chk("t4_before_digit", digit, 4'd5);
    clk1();
    btn_run = 1'b0;
    btn_clr = 1'b0;
    chk_all_zero("t4_clr");
    clk1();
    chk_all_zero("t4_after");

    // 5: asynchronous reset on a tick with digit = 7
    repeat (3) clk1();
    press_run(1'b1);
    expect_step("t5a", 4'd1, 1'b0);
    repeat (24) clk1();
    chk("t5_digit7", digit, 4'd7);
    chk("t5_tick7", 4'(tick), 4'd1);
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("t5_async");
    #2;
    rst = 1'b0;
    clk1();
    chk("t5_idle", 4'(running), 4'd0);
    press_run(1'b1);
    expect_step("t5b", 4'd1, 1'b0);

    // 6: without debounce a 2-cycle glitch is a valid press
    do_reset();
    btn_run = 1'b1;
    clk1();
    clk1();
    btn_run = 1'b0;
    clk1();
    chk("t6_glitch_run", 4'(running), 4'd1);
`else
    // 6: with debounce a 2-cycle glitch is ignored
    btn_run = 1'b1;
    clk1();
    clk1();
    btn_run = 1'b0;
    for (int i = 0; i < 10; i++) begin
      clk1();
      chk("t6_glitch_idle", 4'(running), 4'd0);
    end
    // 3-cycle press: debounced level flips after edge 5, state at edge 6
    btn_run = 1'b1;
    clk1();
    clk1();
    clk1();
    btn_run = 1'b0;
    clk1();
    chk("t6_deb_e4", 4'(running), 4'd0);
    clk1();
    chk("t6_deb_e5", 4'(running), 4'd0);
    clk1();
    chk("t6_deb_e6", 4'(running), 4'd1);
    expect_step("t6_step", 4'd1, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
